// File: rtl/uart_rx_if.sv
// Byte-stream bundle between the UART receiver and its consumer, plus debug/status.
// The master side is the receiver; the slave side drives the line and the ready.
interface uart_rx_if;
   logic       rx_in;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;
   logic [1:0] state;

   modport master (
      input  rx_in, rx_ready,
      output rx_data, rx_valid, frame_err, overrun, busy, state
   );

   modport slave (
      output rx_in, rx_ready,
      input  rx_data, rx_valid, frame_err, overrun, busy, state
   );
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: 8x oversampling from a phase-accumulator tick, LSB-first
// deserialiser with stop-bit check and a valid/ready byte output.
module uart_rx #(
   parameter int ACC_WIDTH = 20,
   parameter int INCREMENT = 1448
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

   localparam logic [ACC_WIDTH:0] INC = (ACC_WIDTH+1)'(INCREMENT);

   logic [ACC_WIDTH:0] r_acc;
   logic               w_tick;
   logic               r_sync1;
   logic               r_sync2;
   logic               r_prev;
   state_t             r_state;
   state_t             w_state_nxt;
   logic [2:0]         r_tc;
   logic [2:0]         w_tc_nxt;
   logic [2:0]         r_idx;
   logic [2:0]         w_idx_nxt;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_nxt;
   logic               w_deliver;
   logic               w_ferr;
   logic [7:0]         r_data;
   logic               r_valid;
   logic               r_ferr;
   logic               r_overrun;

   // The carry out of the accumulator is the one-clk oversample enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_acc <= '0;
      else      r_acc <= {1'b0, r_acc[ACC_WIDTH-1:0]} + INC;
   end

   assign w_tick = r_acc[ACC_WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= bus.rx_in;
         r_sync2 <= r_sync1;
         if (w_tick) r_prev <= r_sync2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_tc    <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tc    <= w_tc_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tc_nxt    = r_tc;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_deliver   = 1'b0;
      w_ferr      = 1'b0;
      if (w_tick) begin
         case (r_state)
            IDLE: begin
               // Only a 1->0 transition starts a frame, so a held-low line is ignored.
               if (!r_sync2 && r_prev) begin
                  w_state_nxt = START;
                  w_tc_nxt    = 3'd0;
               end
            end
            START: begin
               w_tc_nxt = r_tc + 3'd1;
               if (r_tc == 3'd3) begin
                  w_tc_nxt    = 3'd0;
                  w_idx_nxt   = 3'd0;
                  w_state_nxt = r_sync2 ? IDLE : DATA;
               end
            end
            DATA: begin
               w_tc_nxt = r_tc + 3'd1;
               if (r_tc == 3'd7) begin
                  w_tc_nxt             = 3'd0;
                  w_shift_nxt[r_idx]   = r_sync2;
                  if (r_idx == 3'd7) w_state_nxt = STOP;
                  else               w_idx_nxt   = r_idx + 3'd1;
               end
            end
            STOP: begin
               w_tc_nxt = r_tc + 3'd1;
               if (r_tc == 3'd7) begin
                  w_tc_nxt    = 3'd0;
                  w_state_nxt = IDLE;
                  w_deliver   = r_sync2;
                  w_ferr      = !r_sync2;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // A delivery coinciding with an accept replaces the byte without flagging overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         if (w_deliver) begin
            if (!r_valid || bus.rx_ready) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && bus.rx_ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

   assign bus.rx_data   = r_data;
   assign bus.rx_valid  = r_valid;
   assign bus.frame_err = r_ferr;
   assign bus.overrun   = r_overrun;
   assign bus.busy      = (r_state != IDLE);
   assign bus.state     = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx with a fast baud (tick every 2 clks, 16 clks per bit);
// expected bytes are queued at stimulus time and popped by an output monitor.
module tb_uart_rx;

   logic clk = 1'b0;
   logic rst = 1'b0;

   uart_rx_if bus ();

   uart_rx #(
      .ACC_WIDTH (4),
      .INCREMENT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   localparam int BIT_CLKS = 16;

   logic [7:0] exp_q[$];
   int         n_checks  = 0;
   int         n_fail    = 0;
   int         fe_count  = 0;
   int         n_present = 0;
   logic       pv        = 1'b0;
   logic       pr        = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Output monitor: a byte is newly presented when rx_valid rises, or stays high
   // right after an accept (consume-and-load in the same clk).
   always @(negedge clk) begin
      if (rst) begin
         if (bus.frame_err) fe_count++;
         if (bus.rx_valid && (!pv || pr)) begin
            n_present++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got 0x%0h expected none", bus.rx_data);
            end else begin
               check("rx_byte", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
            end
         end
         pv = bus.rx_valid;
         pr = bus.rx_ready;
      end else begin
         pv = 1'b0;
         pr = 1'b0;
      end
   end

   task automatic drive_bit(input logic v);
      bus.rx_in = v;
      repeat (BIT_CLKS) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_bit);
   endtask

   task automatic idle_bits(input int n);
      bus.rx_in = 1'b1;
      repeat (BIT_CLKS * n) @(posedge clk);
      #1;
   endtask

   task automatic accept_pulse();
      bus.rx_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_ready = 1'b0;
   endtask

   // STOP is sampled on its 8th tick, i.e. 16 clks after STOP is entered.
   task automatic ready_on_delivery();
      int   waited;
      logic found;
      found  = 1'b0;
      waited = 0;
      while (!found && waited < 400) begin
         @(negedge clk);
         waited++;
         if (bus.state == 2'b11) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_stop: got timeout expected state STOP");
      end else begin
         repeat (15) @(posedge clk);
         #1;
         bus.rx_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.rx_ready = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   fe_before;
      int   pres_before;
      logic busy_seen;

      bus.rx_in    = 1'b1;
      bus.rx_ready = 1'b0;
      rst          = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("reset_rx_data",   {24'd0, bus.rx_data},   32'h0);
      check("reset_rx_valid",  {31'd0, bus.rx_valid},  32'h0);
      check("reset_frame_err", {31'd0, bus.frame_err}, 32'h0);
      check("reset_overrun",   {31'd0, bus.overrun},   32'h0);
      check("reset_busy",      {31'd0, bus.busy},      32'h0);
      check("reset_state",     {30'd0, bus.state},     32'h0);
      rst = 1'b1;
      idle_bits(2);

      // 1: single frame, then one-clk accept
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      idle_bits(1);
      check("t1_rx_data",   {24'd0, bus.rx_data},  32'hA5);
      check("t1_rx_valid",  {31'd0, bus.rx_valid}, 32'h1);
      check("t1_frame_err", fe_count,              32'd0);
      check("t1_overrun",   {31'd0, bus.overrun},  32'h0);
      accept_pulse();
      check("t1_valid_cleared", {31'd0, bus.rx_valid}, 32'h0);

      // 2: overrun, then accept on the exact delivery clk
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      idle_bits(1);
      check("t2_first_overrun", {31'd0, bus.overrun}, 32'h0);
      send_frame(8'h81, 1'b1);
      idle_bits(1);
      check("t2_data_kept",  {24'd0, bus.rx_data},  32'h3C);
      check("t2_overrun",    {31'd0, bus.overrun},  32'h1);
      check("t2_valid_held", {31'd0, bus.rx_valid}, 32'h1);
      exp_q.push_back(8'h55);
      fork
         send_frame(8'h55, 1'b1);
         ready_on_delivery();
      join
      idle_bits(1);
      check("t2_swap_data",    {24'd0, bus.rx_data},  32'h55);
      check("t2_swap_valid",   {31'd0, bus.rx_valid}, 32'h1);
      check("t2_swap_overrun", {31'd0, bus.overrun},  32'h1);
      accept_pulse();
      check("t2_overrun_cleared", {31'd0, bus.overrun},  32'h0);
      check("t2_valid_cleared",   {31'd0, bus.rx_valid}, 32'h0);

      // 3: bad stop bit followed by a 40-bit break
      fe_before   = fe_count;
      pres_before = n_present;
      send_frame(8'h00, 1'b0);
      bus.rx_in = 1'b0;
      repeat (BIT_CLKS * 40) @(posedge clk);
      #1;
      check("t3_one_frame_err", fe_count - fe_before, 32'd1);
      check("t3_valid_same",    {31'd0, bus.rx_valid}, 32'h0);
      check("t3_data_same",     {24'd0, bus.rx_data},  32'h55);
      check("t3_state_idle",    {30'd0, bus.state},    32'h0);
      idle_bits(3);
      check("t3_no_refire",    fe_count - fe_before,   32'd1);
      check("t3_no_new_frame", n_present - pres_before, 32'd0);

      // 4: 4-clk low glitch
      fe_before   = fe_count;
      pres_before = n_present;
      busy_seen   = 1'b0;
      fork
         begin
            bus.rx_in = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            bus.rx_in = 1'b1;
            repeat (40) @(posedge clk);
            #1;
         end
         begin
            repeat (44) @(negedge clk) if (bus.busy) busy_seen = 1'b1;
         end
      join
      check("t4_glitch_started", {31'd0, busy_seen},     32'h1);
      check("t4_state_idle",     {30'd0, bus.state},     32'h0);
      check("t4_no_valid",       {31'd0, bus.rx_valid},  32'h0);
      check("t4_no_frame_err",   fe_count - fe_before,   32'd0);
      check("t4_no_byte",        n_present - pres_before, 32'd0);
      idle_bits(1);

      // 5: asynchronous reset mid-DATA, then a clean frame
      fe_before = fe_count;
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (56) @(posedge clk);
            #2;
            check("t5_in_data", {30'd0, bus.state}, 32'h2);
            rst = 1'b0;
            #1;
            check("t5_rst_rx_data",   {24'd0, bus.rx_data},   32'h0);
            check("t5_rst_rx_valid",  {31'd0, bus.rx_valid},  32'h0);
            check("t5_rst_frame_err", {31'd0, bus.frame_err}, 32'h0);
            check("t5_rst_overrun",   {31'd0, bus.overrun},   32'h0);
            check("t5_rst_busy",      {31'd0, bus.busy},      32'h0);
            check("t5_rst_state",     {30'd0, bus.state},     32'h0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
         end
      join
      idle_bits(2);
      pres_before = n_present;
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1);
      idle_bits(2);
      check("t5_one_byte",   n_present - pres_before, 32'd1);
      check("t5_rx_data",    {24'd0, bus.rx_data},    32'h12);
      check("t5_no_flags",   fe_count - fe_before,    32'd0);
      accept_pulse();

      // 6: back-to-back frames with the consumer always ready
      pres_before  = n_present;
      fe_before    = fe_count;
      bus.rx_ready = 1'b1;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      send_frame(8'h03, 1'b1);
      idle_bits(2);
      bus.rx_ready = 1'b0;
      check("t6_three_bytes", n_present - pres_before, 32'd3);
      check("t6_no_frame_err", fe_count - fe_before,   32'd0);
      check("t6_no_overrun",  {31'd0, bus.overrun},    32'h0);
      check("t6_valid_clear", {31'd0, bus.rx_valid},   32'h0);

      check("queue_empty",   exp_q.size(), 32'd0);
      check("total_bytes",   n_present,    32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8-N-1 UART receiver; the receive-side counterpart of the team's uart_tx.
- Oversamples the serial line at 8x the bit rate. The 8x tick comes from an internal phase-accumulator baud generator.
- Deserialises one byte per frame, LSB first, and checks the stop bit.
- Presents the byte to a downstream consumer over a valid/ready handshake, with framing and overrun flags.

Parameters:
- ACC_WIDTH, 20: width of the phase accumulator, excluding the carry bit.
- INCREMENT, 1448: accumulator step per clk; oversample tick rate = f_clk*INCREMENT/2^ACC_WIDTH (default is about 8x115200 at 667 MHz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- rx_in  in  1  serial line; idles high; asynchronous to clk.
- rx_ready  in  1  consumer accepts the byte in any cycle where rx_valid=1.
- rx_data  out  8  last good received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- frame_err  out  1  one-clk pulse: stop bit sampled 0.
- overrun  out  1  sticky: a good byte was lost because rx_valid was still set.
- busy  out  1  high in any state other than IDLE.
- state  out  2  FSM state, exported for debug.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst=0:
  - acc=0, tick counter=0, bit index=0, shift register=0.
  - Synchroniser flops=1; state=IDLE.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame with no flags raised.
- Tick generator:
  - acc (ACC_WIDTH+1 bits) <= acc[ACC_WIDTH-1:0] + INCREMENT every clk.
  - tick = acc[ACC_WIDTH]: a one-clk enable, not a derived clock.
- Input: rx_in passes through a 2-flop synchroniser; rxs = second flop. All FSM decisions use rxs on tick cycles only.
- States: IDLE=00, START=01, DATA=10, STOP=11. A 3-bit tick counter tc counts ticks within a bit.
- IDLE: on a tick with rxs=0 and the previous tick's rxs=1 (falling edge), go to START with tc=0. A line held low never re-triggers.
- START: on each tick tc++. At tc==3 (mid-bit, 4th tick):
  - rxs=0: go to DATA, tc=0, bit index=0.
  - rxs=1 (glitch): return to IDLE with no flags.
- DATA: on each tick tc++. When tc==7 (8th tick):
  - Shift rxs into bit[bit index], LSB first.
  - If bit index==7, go to STOP with tc=0; else bit index++.
- STOP: on the 8th tick, sample rxs and return to IDLE.
  - rxs=1: good frame, byte delivered per the handshake rules.
  - rxs=0: frame_err pulses for exactly one clk; rx_data and rx_valid unchanged.
  - IDLE then needs a fresh 1->0 edge before the next frame, so a break condition yields exactly one frame_err.
- Handshake (evaluated in the delivery cycle):
  - rx_valid=0: rx_data <= byte, rx_valid <= 1.
  - rx_valid=1 and rx_ready=1 in the same cycle: old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0: new byte discarded, overrun <= 1.
  - In any other cycle, rx_valid=1 and rx_ready=1 clear rx_valid and clear overrun.
- Latency: rx_valid rises one clk after the STOP-sample tick, i.e. about 9.5 bit times after the start edge plus 2 synchroniser clks.
- busy = (state != IDLE), combinational from state.

Test Plan:
Bench uses ACC_WIDTH=4, INCREMENT=8 (tick every 2 clks, 1 bit = 16 clks).
1. Drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), rx_ready=0 -> rx_data=0xA5, rx_valid=1, frame_err=0, overrun=0. Then rx_ready=1 for 1 clk -> rx_valid=0.
2. Send 0x3C, then 0x81 without asserting rx_ready -> rx_data stays 0x3C, overrun=1. Assert rx_ready on the exact delivery clk of a third byte 0x55 -> rx_data=0x55, rx_valid=1, and the next accept clears overrun.
3. Frame 0x00 with stop bit 0, line then held low for 40 bits -> exactly one frame_err pulse, rx_valid unchanged, state=IDLE; no second frame until the line returns high and falls again.
4. Low glitch of 4 clks (2 ticks) on an idle line -> state returns to IDLE, no rx_valid, no frame_err.
5. Assert rst=0 asynchronously mid-DATA of frame 0xFF, release, then send 0x12 -> all outputs 0 during reset, and exactly one byte 0x12 is received.
6. Back-to-back frames 0x01, 0x02, 0x03 (stop bit immediately followed by start), each accepted -> three rx_valid events in order, no flags.
